// File: rtl/fdct_8x8.sv
// Forward 8x8 DCT: level-shift, Tmp = T*Xs, Y = Tmp*T^T with one MAC per clock.
// Coefficient packing, scale and table match the idct block input format.
module fdct_8x8 #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 11,
    parameter int unsigned SCALE  = 10000
) (
    input  logic                   Clock,
    input  logic                   reset,
    input  logic                   Enable,
    input  logic [64*PIX_W-1:0]    A,
    output logic [64*COEF_W-1:0]   C,
    output logic                   done,
    output logic                   busy
);

    localparam int unsigned XS_W  = PIX_W + 1;
    localparam int unsigned T_W   = 14;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned IDX_W = 9;

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(SCALE / 2);
    localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(SCALE);
    localparam logic signed [ACC_W-1:0] Y_MAX   = ACC_W'((1 << (COEF_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN   = -ACC_W'(1 << (COEF_W - 1));
    localparam logic [XS_W-1:0]         LEVEL   = XS_W'(1 << (PIX_W - 1));

    localparam logic signed [T_W-1:0] T_TAB [64] = '{
         14'sd3536,  14'sd3536,  14'sd3536,  14'sd3536,  14'sd3536,  14'sd3536,  14'sd3536,  14'sd3536,
         14'sd4904,  14'sd4157,  14'sd2778,  14'sd975,  -14'sd975,  -14'sd2778, -14'sd4157, -14'sd4904,
         14'sd4619,  14'sd1913, -14'sd1913, -14'sd4619, -14'sd4619, -14'sd1913,  14'sd1913,  14'sd4619,
         14'sd4157, -14'sd975,  -14'sd4904, -14'sd2778,  14'sd2778,  14'sd4904,  14'sd975,  -14'sd4157,
         14'sd3536, -14'sd3536, -14'sd3536,  14'sd3536,  14'sd3536, -14'sd3536, -14'sd3536,  14'sd3536,
         14'sd2778, -14'sd4904,  14'sd975,   14'sd4157, -14'sd4157, -14'sd975,   14'sd4904, -14'sd2778,
         14'sd1913, -14'sd4619,  14'sd4619, -14'sd1913, -14'sd1913,  14'sd4619, -14'sd4619,  14'sd1913,
         14'sd975,  -14'sd2778,  14'sd4157, -14'sd4904,  14'sd4904, -14'sd4157,  14'sd2778, -14'sd975
    };

    typedef enum logic [1:0] {IDLE, P1, P2, OUT} state_e;

    state_e                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [XS_W-1:0]    xs_q  [8][8];
    logic signed [COEF_W-1:0]  tmp_q [8][8];
    logic signed [COEF_W-1:0]  yr_q  [8][8];
    logic [64*COEF_W-1:0]      c_q;
    logic                      done_q;
    logic                      busy_q;

    logic [2:0]                i, j, k;
    logic signed [T_W-1:0]     opa;
    logic signed [COEF_W-1:0]  opb;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_rnd;

    // Round half away from zero; signed division truncates toward zero.
    function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] biased;
        biased = (a >= 0) ? (a + HALF) : (a - HALF);
        return biased / DIVISOR;
    endfunction

    function automatic logic signed [COEF_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > Y_MAX) begin
            return COEF_W'(Y_MAX);
        end else if (a < Y_MIN) begin
            return COEF_W'(Y_MIN);
        end
        return COEF_W'(a);
    endfunction

    assign i = idx_q[8:6];
    assign j = idx_q[5:3];
    assign k = idx_q[2:0];

    // Pass 1 multiplies T[i][k]*Xs[k][j]; pass 2 multiplies Tmp[i][k]*T[j][k].
    always_comb begin
        opa = T_TAB[{j, k}];
        opb = tmp_q[i][k];
        if (state_q == P1) begin
            opa = T_TAB[{i, k}];
            opb = COEF_W'(xs_q[k][j]);
        end
        prod    = ACC_W'(opa) * ACC_W'(opb);
        acc_sum = acc_q + prod;
        acc_rnd = rnd(acc_sum);
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    xs_q[r][c]  <= '0;
                    tmp_q[r][c] <= '0;
                    yr_q[r][c]  <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= Enable;
                    if (Enable) begin
                        idx_q   <= '0;
                        acc_q   <= '0;
                        state_q <= P1;
                        for (int r = 0; r < 8; r++) begin
                            for (int c = 0; c < 8; c++) begin
                                xs_q[r][c]  <= XS_W'({1'b0, A[(r*8+c)*PIX_W +: PIX_W]}) - LEVEL;
                                tmp_q[r][c] <= '0;
                            end
                        end
                    end
                end
                P1: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (k == 3'd7) begin
                        tmp_q[i][j] <= COEF_W'(acc_rnd);
                        acc_q       <= '0;
                    end else begin
                        acc_q <= acc_sum;
                    end
                    if (idx_q == '1) begin
                        state_q <= P2;
                    end
                end
                P2: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (k == 3'd7) begin
                        yr_q[i][j] <= sat(acc_rnd);
                        acc_q      <= '0;
                    end else begin
                        acc_q <= acc_sum;
                    end
                    if (idx_q == '1) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    for (int u = 0; u < 8; u++) begin
                        for (int v = 0; v < 8; v++) begin
                            c_q[(u*8+v)*COEF_W +: COEF_W] <= yr_q[u][v];
                        end
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C    = c_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_fdct_8x8.sv
// Directed bench for fdct_8x8: flat images, single-pixel impulse, mid-run reset, back-to-back.
module tb_fdct_8x8;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned COEF_W = 11;

    logic                  Clock;
    logic                  reset;
    logic                  Enable;
    logic [64*PIX_W-1:0]   A;
    logic [64*COEF_W-1:0]  C;
    logic                  done;
    logic                  busy;

    int vectors = 0;
    int errors  = 0;

    fdct_8x8 dut (
        .Clock  (Clock),
        .reset  (reset),
        .Enable (Enable),
        .A      (A),
        .C      (C),
        .done   (done),
        .busy   (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int coef(input int u, input int v);
        logic signed [COEF_W-1:0] y;
        y = C[(u*8+v)*COEF_W +: COEF_W];
        return int'(y);
    endfunction

    task automatic set_all(input logic [PIX_W-1:0] pix);
        for (int n = 0; n < 64; n++) A[n*PIX_W +: PIX_W] = pix;
    endtask

    // Pulse Enable for the start edge and count edges until done is seen (-1 on timeout).
    task automatic run(output int lat);
        @(negedge Clock);
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        Enable = 1'b0;
        check("busy_after_start", int'(busy), 1);
        lat = -1;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge Clock);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int nz;
        int saw_done;

        reset  = 1'b0;
        Enable = 1'b0;
        A      = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_c_nonzero", int'(C != '0), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge Clock);
        reset = 1'b1;

        // Mid-grey: level shift cancels, every coefficient is zero.
        set_all(8'd128);
        run(lat);
        check("t1_latency", lat, 1025);
        nz = 0;
        for (int n = 0; n < 64; n++) if (coef(n / 8, n % 8) != 0) nz++;
        check("t1_nonzero_coefs", nz, 0);
        @(posedge Clock);
        #1;
        check("t1_done_cleared", int'(done), 0);
        check("t1_busy_cleared", int'(busy), 0);

        // Black: DC -1024, AC zero.
        set_all(8'd0);
        run(lat);
        check("t2_latency", lat, 1025);
        check("t2_y00", coef(0, 0), -1024);
        nz = 0;
        for (int n = 1; n < 64; n++) if (coef(n / 8, n % 8) != 0) nz++;
        check("t2_ac_nonzero", nz, 0);

        // White: DC 1016, AC zero.
        set_all(8'd255);
        run(lat);
        check("t3_latency", lat, 1025);
        check("t3_y00", coef(0, 0), 1016);
        nz = 0;
        for (int n = 1; n < 64; n++) if (coef(n / 8, n % 8) != 0) nz++;
        check("t3_ac_nonzero", nz, 0);

        // Single bright pixel at (0,0): Tmp[i][0] = rnd(T[i][0]*127).
        set_all(8'd128);
        A[7:0] = 8'd255;
        run(lat);
        check("t4_latency", lat, 1025);
        check("t4_y00", coef(0, 0), 16);
        check("t4_y01", coef(0, 1), 22);
        check("t4_y10", coef(1, 0), 22);
        check("t4_y11", coef(1, 1), 30);
        check("t4_y07", coef(0, 7), 4);
        check("t4_y70", coef(7, 0), 4);
        check("t4_y77", coef(7, 7), 1);
        check("t4_y23", coef(2, 3), 25);

        // Reset at edge 600 aborts the transform and clears C.
        set_all(8'd255);
        @(negedge Clock);
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        Enable = 1'b0;
        repeat (600) @(posedge Clock);
        #1;
        reset = 1'b0;
        #1;
        check("t5_c_nonzero", int'(C != '0), 0);
        check("t5_done", int'(done), 0);
        check("t5_busy", int'(busy), 0);
        @(negedge Clock);
        reset = 1'b1;
        saw_done = 0;
        for (int n = 0; n < 1100; n++) begin
            @(posedge Clock);
            #1;
            if (done) saw_done = 1;
        end
        check("t5_spurious_done", saw_done, 0);
        check("t5_busy_after", int'(busy), 0);

        // Enable held high: A change during busy ignored, done pulses 1026 edges apart.
        set_all(8'd0);
        @(negedge Clock);
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        set_all(8'd255);
        lat = -1;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge Clock);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("t6_first_latency", lat, 1025);
        check("t6_first_y00", coef(0, 0), -1024);
        check("t6_first_y01", coef(0, 1), 0);
        lat = -1;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge Clock);
            #1;
            if (n == 1) begin
                check("t6_restart_busy", int'(busy), 1);
                check("t6_restart_done", int'(done), 0);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        Enable = 1'b0;
        check("t6_spacing", lat, 1026);
        check("t6_second_y00", coef(0, 0), 1016);
        check("t6_second_y10", coef(1, 0), 0);
        @(posedge Clock);
        #1;
        check("t6_busy_end", int'(busy), 0);
        repeat (5) @(posedge Clock);
        #1;
        check("t6_c_hold", coef(0, 0), 1016);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
